darkmm_router: RTL and testbench
================================

Name: darkmm_router

Overview:
- Parametrised successor to the single-ROM/single-RAM memory mapper.
- Routes one core data-bus request to one of NREG address regions.
- Each region is defined by a base/mask parameter pair; the target sees the region-relative offset.
- Adds behaviour the fixed mapper lacks: registered request handshake, per-access wait states, timeout and unmapped-address error responses, and a sticky error-capture register.
- Sits between the core datapath bus and on-chip ROM, RAM and peripheral targets.

Parameters:
- NREG, 4, number of target regions (1..8).
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- REG_BASE, {32'h4000_0000,32'h8000_0000,32'h2000_0000,32'h0000_0000}, packed NREG*AW region bases; region i is at bits [i*AW +: AW].
- REG_MASK, {32'hC000_0000,32'hC000_0000,32'hE000_0000,32'hE000_0000}, packed NREG*AW decode masks; set bits are compared against the base.
- TIMEOUT, 255, maximum wait cycles in ACCESS before an error response (1..2^TW-1).
- TW, 8, timeout counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- res  in  1  reset, asynchronous, active-low.
- core_en  in  1  request strobe; sampled only when core_ready=1.
- core_rw  in  1  1=write, 0=read.
- core_be  in  DW/8  byte enables.
- core_addr  in  AW  byte address.
- core_wdata  in  DW  write data.
- core_ready  out  1  router idle, request may be issued.
- core_valid  out  1  one-cycle completion pulse.
- core_err  out  1  qualifies core_valid: access failed.
- core_rdata  out  DW  read data, meaningful when core_valid=1.
- tgt_en  out  NREG  one-hot target select, held for the whole access.
- tgt_rw  out  1  latched rw.
- tgt_be  out  DW/8  latched byte enables.
- tgt_addr  out  AW  latched offset, core_addr & ~REG_MASK[i].
- tgt_wdata  out  DW  latched write data.
- tgt_rdata  in  NREG*DW  per-target read data.
- tgt_ack  in  NREG  per-target completion; only the selected bit is honoured.
- err_flag  out  1  sticky error indicator.
- err_addr  out  AW  full address of the first unacknowledged error.
- err_clr  in  1  clears err_flag and err_addr.

Behaviour:
- Reset (res=0, async): state=IDLE, core_ready=1, all other outputs 0, timer=0. A reset mid-access drops tgt_en immediately; no completion is issued.
- Decode (combinational, on core_addr): hit[i] = ((core_addr & MASK[i]) == BASE[i]). On overlap the lowest index wins. No hit means unmapped.
- FSM states: IDLE, ACCESS, DONE, ERR.
- IDLE:
  - core_ready=1.
  - On core_en: latch rw, be, wdata, full address, region index, and offset.
  - Hit goes to ACCESS; unmapped goes to ERR.
  - core_en=0 stays in IDLE.
- ACCESS:
  - core_ready=0; tgt_en[sel]=1; all tgt_* signals stable.
  - The timer increments every cycle, starting at 0 on entry.
  - When tgt_ack[sel]=1: capture tgt_rdata[sel] (reads) or 0 (writes) into core_rdata, go to DONE.
  - When the timer reaches TIMEOUT with no ack, go to ERR. If ack and timeout occur in the same cycle, ack wins.
  - Acks on non-selected bits are ignored.
- DONE: core_valid=1, core_err=0 for one cycle, then IDLE. tgt_en=0.
- ERR: core_valid=1, core_err=1, core_rdata=0 for one cycle, then IDLE.
  - If err_flag=0, set err_flag=1 and err_addr=latched address.
  - If err_flag=1, err_addr is kept (first error wins).
- err_clr: clears err_flag and err_addr on the next edge. If asserted in the same cycle as an ERR capture, the capture wins (flag=1, new address).
- Latency:
  - Ack in the first ACCESS cycle: core_valid 2 cycles after the core_en sample edge.
  - Each wait cycle adds 1.
  - Unmapped access: core_valid exactly 1 cycle after the sample.
- Throughput: one outstanding access. The next request can be accepted in the cycle after core_valid.
- core_rdata is held until the next capture. core_valid and core_err are 0 outside DONE/ERR.

Test Plan:
- Read region 0 (addr 32'h0000_0010), tgt_ack[0] in first ACCESS cycle, tgt_rdata0=32'hCAFE_0001 -> tgt_en=4'b0001, tgt_addr=32'h10, core_valid 2 cycles after sample, core_rdata=32'hCAFE_0001, core_err=0.
- Write region 3 (addr 32'h4000_0100, be=4'b0011, wdata=32'h1234_5678), ack after 3 wait cycles -> tgt_en=4'b1000 held 4 cycles, tgt_addr=32'h100, tgt_be=4'b0011, core_valid 5 cycles after sample, core_rdata=0.
- Unmapped addr 32'hC000_0000 -> no tgt_en, core_valid+core_err 1 cycle after sample, err_flag=1, err_addr=32'hC000_0000.
- Region 1, TIMEOUT=4, no ack -> ERR after 4 ACCESS cycles, core_err=1. A second timeout at 32'h2000_0004 leaves err_addr at the first address. err_clr together with a third error -> flag=1, err_addr=third address.
- Assert res=0 during ACCESS with tgt_ack stray on non-selected bit -> tgt_en=0 immediately, no core_valid, core_ready=1 after release. A stray ack never completes the access.

Source files
------------

// File: rtl/darkmm_router.sv
// Data-bus router: decodes one core request into one of NREG base/mask regions,
// runs a single outstanding access with wait states, timeout and sticky error capture.
module darkmm_router #(
    parameter int                    NREG     = 4,
    parameter int                    AW       = 32,
    parameter int                    DW       = 32,
    parameter logic [NREG*AW-1:0]    REG_BASE = {32'h4000_0000, 32'h8000_0000, 32'h2000_0000, 32'h0000_0000},
    parameter logic [NREG*AW-1:0]    REG_MASK = {32'hC000_0000, 32'hC000_0000, 32'hE000_0000, 32'hE000_0000},
    parameter int                    TIMEOUT  = 255,
    parameter int                    TW       = 8
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 core_en,
    input  logic                 core_rw,
    input  logic [DW/8-1:0]      core_be,
    input  logic [AW-1:0]        core_addr,
    input  logic [DW-1:0]        core_wdata,
    output logic                 core_ready,
    output logic                 core_valid,
    output logic                 core_err,
    output logic [DW-1:0]        core_rdata,
    output logic [NREG-1:0]      tgt_en,
    output logic                 tgt_rw,
    output logic [DW/8-1:0]      tgt_be,
    output logic [AW-1:0]        tgt_addr,
    output logic [DW-1:0]        tgt_wdata,
    input  logic [NREG*DW-1:0]   tgt_rdata,
    input  logic [NREG-1:0]      tgt_ack,
    output logic                 err_flag,
    output logic [AW-1:0]        err_addr,
    input  logic                 err_clr
);
    localparam int SW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;

    state_t              state_reg, state_next;
    logic [TW-1:0]       timer_reg;
    logic [SW-1:0]       sel_reg;
    logic                rw_reg;
    logic [DW/8-1:0]     be_reg;
    logic [AW-1:0]       addr_reg;
    logic [AW-1:0]       off_reg;
    logic [DW-1:0]       wdata_reg;
    logic [DW-1:0]       rdata_reg;
    logic                err_flag_reg;
    logic [AW-1:0]       err_addr_reg;

    logic [NREG-1:0]     hit;
    logic [DW-1:0]       rdata_arr [NREG];
    logic                dec_hit;
    logic [SW-1:0]       dec_idx;
    logic [AW-1:0]       dec_mask;
    logic                sel_ack;
    logic                timed_out;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_region
            assign hit[gi]       = ((core_addr & REG_MASK[gi*AW +: AW]) == REG_BASE[gi*AW +: AW]);
            assign rdata_arr[gi] = tgt_rdata[gi*DW +: DW];
        end
    endgenerate

    // Walk downwards so the lowest matching index is the one left standing.
    always_comb begin
        dec_hit  = 1'b0;
        dec_idx  = '0;
        dec_mask = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (hit[i]) begin
                dec_hit  = 1'b1;
                dec_idx  = SW'(i);
                dec_mask = REG_MASK[i*AW +: AW];
            end
        end
    end

    assign sel_ack   = tgt_ack[sel_reg];
    assign timed_out = (timer_reg == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge res) begin
        if (!res) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (core_en) state_next = dec_hit ? ACCESS : ERR;
            ACCESS:  if (sel_ack) state_next = DONE;
                     else if (timed_out) state_next = ERR;
            DONE:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        core_ready = (state_reg == IDLE);
        core_valid = (state_reg == DONE) || (state_reg == ERR);
        core_err   = (state_reg == ERR);
        tgt_en     = '0;
        if (state_reg == ACCESS) tgt_en[sel_reg] = 1'b1;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            timer_reg <= '0;
            sel_reg   <= '0;
            rw_reg    <= 1'b0;
            be_reg    <= '0;
            addr_reg  <= '0;
            off_reg   <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            if (state_reg == IDLE) begin
                timer_reg <= '0;
                if (core_en) begin
                    sel_reg   <= dec_idx;
                    rw_reg    <= core_rw;
                    be_reg    <= core_be;
                    addr_reg  <= core_addr;
                    off_reg   <= core_addr & ~dec_mask;
                    wdata_reg <= core_wdata;
                end
            end else if (state_reg == ACCESS) begin
                timer_reg <= timer_reg + 1'b1;
            end
            // Read data is zeroed on the way into ERR so the error beat never carries stale data.
            if (state_next == ERR && state_reg != ERR)
                rdata_reg <= '0;
            else if (state_reg == ACCESS && sel_ack)
                rdata_reg <= rw_reg ? '0 : rdata_arr[sel_reg];
        end
    end

    // A capture in the ERR beat overrides a simultaneous clear; otherwise the first error is kept.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            err_flag_reg <= 1'b0;
            err_addr_reg <= '0;
        end else if (state_reg == ERR && (!err_flag_reg || err_clr)) begin
            err_flag_reg <= 1'b1;
            err_addr_reg <= addr_reg;
        end else if (err_clr) begin
            err_flag_reg <= 1'b0;
            err_addr_reg <= '0;
        end
    end

    assign core_rdata = rdata_reg;
    assign tgt_rw     = rw_reg;
    assign tgt_be     = be_reg;
    assign tgt_addr   = off_reg;
    assign tgt_wdata  = wdata_reg;
    assign err_flag   = err_flag_reg;
    assign err_addr   = err_addr_reg;

endmodule

// File: tb/tb_darkmm_router.sv
// Randomised scoreboard bench for darkmm_router: a driver issues requests and plays the targets,
// a monitor pops the expected completion and error-capture state whenever core_valid appears.
module tb_darkmm_router;
    localparam int NREG = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int TO   = 4;
    localparam int TW   = 8;

    logic                clk = 1'b0;
    logic                res;
    logic                core_en, core_rw;
    logic [BW-1:0]       core_be;
    logic [AW-1:0]       core_addr;
    logic [DW-1:0]       core_wdata;
    logic                core_ready, core_valid, core_err;
    logic [DW-1:0]       core_rdata;
    logic [NREG-1:0]     tgt_en;
    logic                tgt_rw;
    logic [BW-1:0]       tgt_be;
    logic [AW-1:0]       tgt_addr;
    logic [DW-1:0]       tgt_wdata;
    logic [NREG*DW-1:0]  tgt_rdata;
    logic [NREG-1:0]     tgt_ack;
    logic                err_flag;
    logic [AW-1:0]       err_addr;
    logic                err_clr;

    darkmm_router #(.NREG(NREG), .AW(AW), .DW(DW), .TIMEOUT(TO), .TW(TW)) dut (
        .clk(clk), .res(res), .core_en(core_en), .core_rw(core_rw), .core_be(core_be),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_ready(core_ready),
        .core_valid(core_valid), .core_err(core_err), .core_rdata(core_rdata),
        .tgt_en(tgt_en), .tgt_rw(tgt_rw), .tgt_be(tgt_be), .tgt_addr(tgt_addr),
        .tgt_wdata(tgt_wdata), .tgt_rdata(tgt_rdata), .tgt_ack(tgt_ack),
        .err_flag(err_flag), .err_addr(err_addr), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Region map as a plain table, region i first.
    logic [AW-1:0] rbase [NREG] = '{32'h0000_0000, 32'h2000_0000, 32'h8000_0000, 32'h4000_0000};
    logic [AW-1:0] rmask [NREG] = '{32'hE000_0000, 32'hE000_0000, 32'hC000_0000, 32'hC000_0000};

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
        logic [AW-1:0] addr;
        int unsigned   cyc;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    logic          m_flag   = 1'b0;
    logic [AW-1:0] m_addr   = '0;

    function automatic int model_region(logic [AW-1:0] a);
        for (int i = 0; i < NREG; i++)
            if ((a & rmask[i]) == rbase[i]) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: samples one time unit after the falling edge, when DUT outputs and bench inputs are settled.
    initial begin : monitor
        exp_t e;
        logic chk_err = 1'b0;
        logic cap;
        forever begin
            @(negedge clk);
            #1;
            if (chk_err) begin
                check("err_flag", err_flag, m_flag);
                check("err_addr", err_addr, m_addr);
                chk_err = 1'b0;
            end
            cap = 1'b0;
            if (core_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got core_valid=1 expected no completion (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("core_err", core_err, e.err);
                    check("core_rdata", core_rdata, e.rdata);
                    check("latency_cycle", cyc, e.cyc);
                    $display("txn addr=%08h err=%0d rdata=%08h cycle=%0d", e.addr, core_err, core_rdata, cyc);
                    if (e.err && (!m_flag || err_clr)) begin
                        m_flag  = 1'b1;
                        m_addr  = e.addr;
                        cap     = 1'b1;
                        chk_err = 1'b1;
                    end
                end
            end
            if (!cap && err_clr) begin
                m_flag  = 1'b0;
                m_addr  = '0;
                chk_err = 1'b1;
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        while (!core_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!core_ready) check("ready_timeout", core_ready, 1);
    endtask

    // w = ack after w wait cycles; w >= TO means the target never answers.
    task automatic run_txn(input logic [AW-1:0] a, input logic rw, input logic [BW-1:0] be,
                           input logic [DW-1:0] wd, input int w, input bit clr_in_err);
        int            r;
        int            lat;
        int            t;
        logic [DW-1:0] words [NREG];
        logic [NREG-1:0] sel, stray;
        exp_t          e;
        wait_ready();
        r = model_region(a);
        for (int i = 0; i < NREG; i++) begin
            words[i] = $urandom;
            tgt_rdata[i*DW +: DW] = words[i];
        end
        if (r < 0) begin
            e.err = 1'b1; e.rdata = '0; lat = 1;
        end else if (w < TO) begin
            e.err = 1'b0; e.rdata = rw ? '0 : words[r]; lat = 2 + w;
        end else begin
            e.err = 1'b1; e.rdata = '0; lat = TO + 1;
        end
        e.addr = a;
        e.cyc  = cyc + lat;
        sb.push_back(e);
        core_en = 1'b1; core_rw = rw; core_be = be; core_addr = a; core_wdata = wd;
        @(negedge clk);
        core_en = 1'b0; core_addr = $urandom; core_wdata = $urandom;
        if (r < 0) begin
            check("unmapped_tgt_en", tgt_en, 0);
            if (clr_in_err) begin
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
            end
        end else begin
            sel = NREG'(1) << r;
            for (int k = 0; k < TO; k++) begin
                check("tgt_en", tgt_en, sel);
                if (k == 0) begin
                    check("tgt_addr", tgt_addr, a & ~rmask[r]);
                    check("tgt_be", tgt_be, be);
                    check("tgt_rw", tgt_rw, rw);
                    check("tgt_wdata", tgt_wdata, wd);
                end
                stray = NREG'($urandom) & ~sel;
                if (k == w) begin
                    tgt_ack = sel | stray;
                    @(negedge clk);
                    break;
                end
                tgt_ack = stray;
                @(negedge clk);
            end
            tgt_ack = '0;
        end
        t = 0;
        while (sb.size() != 0 && t < TO + 10) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            check("completion_missing", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_mid_access();
        wait_ready();
        core_en = 1'b1; core_rw = 1'b0; core_be = '1; core_addr = 32'h8000_0040; core_wdata = '0;
        @(negedge clk);
        core_en = 1'b0;
        tgt_ack = 4'b1011;
        check("rst_pre_tgt_en", tgt_en, 4'b0100);
        @(negedge clk);
        check("stray_ack_ignored", tgt_en, 4'b0100);
        #2 res = 1'b0;
        #1;
        check("rst_tgt_en", tgt_en, 0);
        check("rst_core_ready", core_ready, 1);
        check("rst_core_valid", core_valid, 0);
        @(negedge clk);
        tgt_ack = '0;
        res = 1'b1;
        m_flag = 1'b0;
        m_addr = '0;
        @(negedge clk);
        check("post_rst_ready", core_ready, 1);
        check("post_rst_err_flag", err_flag, 0);
    endtask

    initial begin : stim
        logic [AW-1:0] a;
        int            kind, r;
        res = 1'b0; core_en = 1'b0; core_rw = 1'b0; core_be = '0; core_addr = '0;
        core_wdata = '0; tgt_rdata = '0; tgt_ack = '0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_core_ready", core_ready, 1);
        check("reset_core_valid", core_valid, 0);
        check("reset_core_err", core_err, 0);
        check("reset_tgt_en", tgt_en, 0);
        check("reset_core_rdata", core_rdata, 0);
        check("reset_err_flag", err_flag, 0);
        check("reset_err_addr", err_addr, 0);
        res = 1'b1;
        @(negedge clk);

        run_txn(32'h0000_0010, 1'b0, 4'b1111, 32'h0, 0, 1'b0);
        run_txn(32'h4000_0100, 1'b1, 4'b0011, 32'h1234_5678, 3, 1'b0);
        run_txn(32'hC000_0000, 1'b0, 4'b1111, 32'h0, 0, 1'b0);
        pulse_clr();
        run_txn(32'h2000_0010, 1'b0, 4'b1111, 32'h0, TO, 1'b0);
        run_txn(32'h2000_0004, 1'b0, 4'b1111, 32'h0, TO, 1'b0);
        run_txn(32'hF000_0000, 1'b1, 4'b0001, 32'hAA, 0, 1'b1);
        run_txn(32'h2000_0020, 1'b0, 4'b1111, 32'h0, TO - 1, 1'b0);
        reset_mid_access();

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 5);
            if (kind < NREG) begin
                r = kind;
                a = rbase[r] | (AW'($urandom) & ~rmask[r]);
            end else begin
                a = $urandom;
            end
            run_txn(a, 1'($urandom), BW'($urandom), $urandom, $urandom_range(0, TO + 1), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 7) == 0) pulse_clr();
        end
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
